// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle CPU datapath (PC, SP, MAR, MDR, IR, Y, register
// bank, ALU, NVCZ flags) driven one micro-op at a time by the control unit.
// Optional build macro: MC_DATAPATH_MEM_TIMEOUT_EN adds a memory-wait
// timeout that aborts a stuck access and raises the sticky mem_err flag.
module mc_datapath #(
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       NREG     = 8,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter logic [WIDTH-1:0]  RESET_SP = '1,
  parameter int unsigned       TIMEOUT  = 255,
  localparam int unsigned      RSEL_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uop_valid,
  output logic              uop_ready,
  input  logic [2:0]        uop_src,
  input  logic [RSEL_W-1:0] uop_rsel,
  input  logic [2:0]        uop_alu,
  input  logic [7:0]        uop_dst,
  input  logic [1:0]        uop_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [WIDTH-1:0]  ir,
  output logic [3:0]        flags,
  output logic              mem_err
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE = 1'b0, ST_MEM = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, sp_q, mar_q, mdr_q, ir_q, y_q;
  logic [WIDTH-1:0] reg_q [NREG];
  logic [3:0]       flags_q;
  logic             mem_req_q, mem_we_q;

  logic             is_mem_s, accept_s, reg_op_s, timeout_hit_s;
  logic [WIDTH-1:0] x_s, z_s;
  logic [WIDTH:0]   res_ext_s;
  logic             c_s, v_s;

  assign is_mem_s  = (uop_mem == 2'd1) || (uop_mem == 2'd2);
  assign accept_s  = uop_valid && (state_q == ST_IDLE);
  assign reg_op_s  = accept_s && !is_mem_s;
  assign uop_ready = (state_q == ST_IDLE);

`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            mem_err_q;

  assign timeout_hit_s = (state_q == ST_MEM) && !mem_ack &&
                         (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign mem_err       = mem_err_q;

  // Count cycles spent waiting in MEM; latch the sticky error on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (state_q == ST_MEM) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_q <= '0;
      end
      if (timeout_hit_s) begin
        mem_err_q <= 1'b1;
      end else begin
        mem_err_q <= mem_err_q;
      end
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign mem_err       = 1'b0;
`endif

  // X bus source select and ALU (Z = f(Y, X)) with carry/borrow and overflow.
  always_comb begin
    x_s       = '0;
    res_ext_s = '0;
    c_s       = 1'b0;
    v_s       = 1'b0;
    case (uop_src)
      3'd0:    x_s = pc_q;
      3'd1:    x_s = sp_q;
      3'd2:    x_s = mdr_q;
      3'd3:    x_s = reg_q[uop_rsel];
      3'd4:    x_s = ir_q;
      3'd5:    x_s = y_q;
      3'd6:    x_s = '0;
      3'd7:    x_s = ONE_W;
      default: x_s = '0;
    endcase
    case (uop_alu)
      3'd0: res_ext_s = {1'b0, x_s};
      3'd1: begin
        res_ext_s = {1'b0, y_q} + {1'b0, x_s};
        c_s = res_ext_s[WIDTH];
        v_s = (y_q[MSB] == x_s[MSB]) && (res_ext_s[MSB] != y_q[MSB]);
      end
      3'd2: begin
        // Top bit of the extended difference is the unsigned borrow.
        res_ext_s = {1'b0, y_q} - {1'b0, x_s};
        c_s = res_ext_s[WIDTH];
        v_s = (y_q[MSB] != x_s[MSB]) && (res_ext_s[MSB] != y_q[MSB]);
      end
      3'd3: res_ext_s = {1'b0, y_q & x_s};
      3'd4: res_ext_s = {1'b0, y_q | x_s};
      3'd5: res_ext_s = {1'b0, y_q ^ x_s};
      3'd6: begin
        res_ext_s = {1'b0, x_s} + ONE_EXT;
        c_s = res_ext_s[WIDTH];
        v_s = !x_s[MSB] && res_ext_s[MSB];
      end
      3'd7: begin
        res_ext_s = {1'b0, x_s} - ONE_EXT;
        c_s = res_ext_s[WIDTH];
        v_s = x_s[MSB] && !res_ext_s[MSB];
      end
      default: res_ext_s = {1'b0, x_s};
    endcase
    z_s = res_ext_s[WIDTH-1:0];
  end

  // Next-state logic: enter MEM on a memory micro-op, leave on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && is_mem_s) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        if (mem_ack || timeout_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MEM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus registered memory request/direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == ST_MEM);
      if (accept_s && is_mem_s) begin
        mem_we_q <= (uop_mem == 2'd2);
      end else if (state_d == ST_IDLE) begin
        mem_we_q <= 1'b0;
      end else begin
        mem_we_q <= mem_we_q;
      end
    end
  end

  // Architectural registers: masked loads from Z (Y from X), MDR from memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      sp_q    <= RESET_SP;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      y_q     <= '0;
      flags_q <= 4'd0;
      for (int i = 0; i < int'(NREG); i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      if (reg_op_s) begin
        if (uop_dst[0]) pc_q  <= z_s;
        if (uop_dst[1]) sp_q  <= z_s;
        if (uop_dst[2]) mar_q <= z_s;
        if (uop_dst[3]) mdr_q <= z_s;
        if (uop_dst[4]) ir_q  <= z_s;
        if (uop_dst[5]) y_q   <= x_s;
        if (uop_dst[6]) reg_q[uop_rsel] <= z_s;
        if (uop_dst[7]) flags_q <= {z_s[MSB], v_s, c_s, (z_s == '0)};
      end else if ((state_q == ST_MEM) && mem_ack && !mem_we_q) begin
        mdr_q <= mem_rdata;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign ir        = ir_q;
  assign flags     = flags_q;

endmodule
